keyboard_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the core to the keyboard. It uses the PS/2 request-to-send sequence and checks for the device acknowledge. It sits beside the `keyboard` receiver on the same `ps2` pins and drives the lines through open-drain enables in the top level. The receiver is held off while `busy` is high.

---
 rtl/keyboard_tx_pkg.sv | 25 ++
 rtl/ps2_clock_filter.sv | 48 ++++
 rtl/keyboard_tx.sv | 166 ++++++++++++++++
 tb/tb_keyboard_tx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/keyboard_tx_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, command bytes and
// the clock-filter depth used by both the transmitter and the receiver.
package keyboard_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_BITS,
    ST_ACK,
    ST_WAIT
  } tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

  localparam int unsigned FILTER_TAPS = 8;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_clock_filter.sv
// PS/2 clock deglitcher: the level changes only once all taps agree; fe marks
// a filtered 1->0 change and stays up for one ce tick.
module ps2_clock_filter
  import keyboard_tx_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic ce,
  input  logic ps2_clk,
  output logic level,
  output logic fe
);

  logic [FILTER_TAPS-1:0] taps_q, taps_d;
  logic                   level_q, level_d;
  logic                   fe_q, fe_d;

  always_comb begin
    taps_d  = taps_q;
    level_d = level_q;
    fe_d    = fe_q;
    if (ce) begin
      taps_d = {taps_q[FILTER_TAPS-2:0], ps2_clk};
      if (&taps_d) begin
        level_d = 1'b1;
      end else if (~|taps_d) begin
        level_d = 1'b0;
      end
      fe_d = level_q & ~level_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      taps_q  <= '1;
      level_q <= 1'b1;
      fe_q    <= 1'b0;
    end else begin
      taps_q  <= taps_d;
      level_q <= level_d;
      fe_q    <= fe_d;
    end
  end

  assign level = level_q;
  assign fe    = fe_q;

endmodule

// File: rtl/keyboard_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits,
// odd parity, stop, then device acknowledge, all through open-drain enables.
module keyboard_tx
  import keyboard_tx_pkg::*;
#(
  parameter int unsigned INHIBIT = 1400,
  parameter int unsigned TIMEOUT = 16383
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] ps2,
  output logic       ps2co,
  output logic       ps2do,
  input  logic       start,
  input  logic [7:0] di,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned TMAX = (INHIBIT > TIMEOUT) ? INHIBIT : TIMEOUT;
  localparam int          TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT - 1);
  localparam logic [TW-1:0] TMO_VAL  = TW'(TIMEOUT);

  tx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    byte_q, byte_d;
  logic          parity_q, parity_d;
  logic          co_q, co_d;
  logic          do_q, do_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          data_q, data_d;
  logic          clk_level, clk_fe;

  ps2_clock_filter u_filter (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .ps2_clk (ps2[0]),
    .level   (clk_level),
    .fe      (clk_fe)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    parity_d = parity_q;
    co_d     = co_q;
    do_d     = do_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    data_d   = ce ? ps2[1] : data_q;

    unique case (state_q)
      ST_IDLE: begin
        co_d = 1'b0;
        do_d = 1'b0;
        if (start) begin
          byte_d   = di;
          parity_d = odd_parity(di);
          timer_d  = '0;
          co_d     = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (ce) begin
          if (timer_q == INH_LAST) begin
            timer_d = '0;
            co_d    = 1'b0;
            do_d    = 1'b1;
            state_d = ST_RTS;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end

      default: begin
        // A clock edge or the WAIT release wins over a coincident timeout.
        if (ce) begin
          if (clk_fe) begin
            timer_d = '0;
            unique case (state_q)
              ST_RTS: begin
                idx_d   = '0;
                do_d    = ~byte_q[0];
                state_d = ST_BITS;
              end
              ST_BITS: begin
                idx_d = idx_q + 4'd1;
                if (idx_d == 4'd9) begin
                  do_d    = 1'b0;
                  state_d = ST_ACK;
                end else if (idx_d == 4'd8) begin
                  do_d = ~parity_q;
                end else begin
                  do_d = ~byte_q[idx_d[2:0]];
                end
              end
              ST_ACK: begin
                if (data_q) begin
                  error_d = 1'b1;
                  state_d = ST_IDLE;
                end else begin
                  state_d = ST_WAIT;
                end
              end
              default: ;
            endcase
          end else if (state_q == ST_WAIT && clk_level && data_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (timer_q + 1'b1 == TMO_VAL) begin
            error_d = 1'b1;
            co_d    = 1'b0;
            do_d    = 1'b0;
            state_d = ST_IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      byte_q   <= '0;
      parity_q <= 1'b0;
      co_q     <= 1'b0;
      do_q     <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      data_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
      parity_q <= parity_d;
      co_q     <= co_d;
      do_q     <= do_d;
      done_q   <= done_d;
      error_q  <= error_d;
      data_q   <= data_d;
    end
  end

  assign ps2co = co_q;
  assign ps2do = do_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_keyboard_tx.sv
// Directed bench for keyboard_tx with an open-drain PS/2 device model.
module tb_keyboard_tx;

  localparam int H = 40;  // device half-period in clock cycles (20 ce ticks)

  logic       clock = 1'b0;
  logic       reset, ce, start;
  logic [7:0] di;
  logic [1:0] ps2;
  logic       ps2co, ps2do, busy, done, error;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch = 1'b0;

  int total = 0, bad = 0;
  int tick_cnt = 0, n_done = 0, n_err = 0, n_both = 0;
  int inh, rts_tick;
  logic [9:0] seen;

  assign ps2[0] = ~(ps2co | dev_clk_low | glitch);
  assign ps2[1] = ~(ps2do | dev_data_low);

  keyboard_tx #(.INHIBIT(1400), .TIMEOUT(16383)) dut (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .ps2   (ps2),
    .ps2co (ps2co),
    .ps2do (ps2do),
    .start (start),
    .di    (di),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  always #5 clock = ~clock;

  initial begin
    ce = 1'b0;
    forever begin
      @(posedge clock);
      #2 ce = ~ce;
    end
  end

  always @(posedge clock) if (ce) tick_cnt <= tick_cnt + 1;

  always @(negedge clock) begin
    if (done) n_done++;
    if (error) n_err++;
    if (done && error) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, output int inh_ticks, output int rts_at);
    int t0;
    @(negedge clock);
    start = 1'b1;
    di    = b;
    @(negedge clock);
    start = 1'b0;
    chk("co_after_start", {31'b0, ps2co}, 1);
    t0 = tick_cnt;
    for (int i = 0; i < 5000 && ps2co; i++) @(negedge clock);
    inh_ticks = tick_cnt - t0;
    rts_at    = tick_cnt;
    chk("rts_start_bit", {31'b0, ps2do}, 1);
  endtask

  task automatic dev_clocks(input int nedges, input int glitch_k, input logic ack,
                            output logic [9:0] bits);
    bits = '0;
    repeat (H) @(negedge clock);
    for (int k = 1; k <= nedges; k++) begin
      if (k == 11) begin
        dev_data_low = ack;
        repeat (H / 2) @(negedge clock);
      end
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clock);
      dev_clk_low = 1'b0;
      @(negedge clock);
      if (k <= 10) bits[k-1] = ps2[1];
      if (k == glitch_k) begin
        repeat (10) @(negedge clock);
        glitch = 1'b1;
        repeat (6) @(negedge clock);
        glitch = 1'b0;
        repeat (H - 17) @(negedge clock);
      end else begin
        repeat (H - 1) @(negedge clock);
      end
    end
    repeat (H) @(negedge clock);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000 && busy; i++) @(negedge clock);
    repeat (2) @(negedge clock);
    chk(tag, {31'b0, busy}, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    di    = '0;
    repeat (4) @(negedge clock);
    chk("rst_ps2co", {31'b0, ps2co}, 0);
    chk("rst_ps2do", {31'b0, ps2do}, 0);
    chk("rst_busy",  {31'b0, busy},  0);
    chk("rst_done",  {31'b0, done},  0);
    chk("rst_error", {31'b0, error}, 0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // 0xED, acknowledged
    send(8'hED, inh, rts_tick);
    chk("inhibit_ticks", inh, 1400);
    dev_clocks(11, 0, 1'b1, seen);
    wait_idle("ed_idle");
    chk("ed_data",   {24'b0, seen[7:0]}, 32'hED);
    chk("ed_parity", {31'b0, seen[8]}, 1);
    chk("ed_stop",   {31'b0, seen[9]}, 1);
    chk("ed_done",   n_done, 1);
    chk("ed_noerr",  n_err, 0);

    // no acknowledge
    send(8'hF4, inh, rts_tick);
    dev_clocks(11, 0, 1'b0, seen);
    wait_idle("nack_idle");
    chk("nack_err",  n_err, 1);
    chk("nack_done", n_done, 1);
    chk("nack_data", {24'b0, seen[7:0]}, 32'hF4);

    // no device clocks: timeout measured from RTS
    send(8'hFF, inh, rts_tick);
    for (int i = 0; i < 40000 && !error; i++) @(negedge clock);
    chk("tmo_error", {31'b0, error}, 1);
    chk("tmo_ticks", tick_cnt - rts_tick, 16383);
    chk("tmo_ps2co", {31'b0, ps2co}, 0);
    chk("tmo_ps2do", {31'b0, ps2do}, 0);
    chk("tmo_busy",  {31'b0, busy}, 0);
    repeat (4) @(negedge clock);
    chk("tmo_errcnt", n_err, 2);

    // reset at bit index 4 (0xED bit4 = 0, so data is being pulled low)
    send(8'hED, inh, rts_tick);
    dev_clocks(5, 0, 1'b1, seen);
    chk("idx4_ps2do", {31'b0, ps2do}, 1);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_ps2co", {31'b0, ps2co}, 0);
    chk("mid_rst_ps2do", {31'b0, ps2do}, 0);
    chk("mid_rst_busy",  {31'b0, busy}, 0);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    chk("mid_rst_nodone", n_done, 1);
    chk("mid_rst_noerr",  n_err, 2);
    send(8'hFF, inh, rts_tick);
    dev_clocks(11, 0, 1'b1, seen);
    wait_idle("ff_idle");
    chk("ff_data",   {24'b0, seen[7:0]}, 32'hFF);
    chk("ff_parity", {31'b0, seen[8]}, 1);
    chk("ff_done",   n_done, 2);

    // start with 0x00 while busy on 0xF4 is ignored
    send(8'hF4, inh, rts_tick);
    @(negedge clock);
    start = 1'b1;
    di    = 8'h00;
    @(negedge clock);
    start = 1'b0;
    dev_clocks(11, 0, 1'b1, seen);
    wait_idle("f4_idle");
    chk("f4_data",   {24'b0, seen[7:0]}, 32'hF4);
    chk("f4_parity", {31'b0, seen[8]}, 0);
    chk("f4_done",   n_done, 3);

    // 3-ce-tick clock glitch during the data bits
    send(8'hED, inh, rts_tick);
    dev_clocks(11, 4, 1'b1, seen);
    wait_idle("gl_idle");
    chk("gl_data",   {24'b0, seen[7:0]}, 32'hED);
    chk("gl_parity", {31'b0, seen[8]}, 1);
    chk("gl_done",   n_done, 4);
    chk("gl_noerr",  n_err, 2);

    chk("done_error_excl", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
